// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle between a cache master and the memory responder.
// One transaction at a time is assumed, so no ID channels are carried.
interface axi_mem_responder_if;
  logic        arvalid;
  logic        arready;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  logic        awvalid;
  logic        awready;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    output awvalid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    input  awvalid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 burst memory slave: one transaction at a time, 64-bit word storage,
// fixed read latency, byte-strobed writes and SLVERR on out-of-range beats.
module axi_mem_responder #(
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          READ_LATENCY = 4,
  parameter logic [63:0] BASE_ADDR    = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  axi_mem_responder_if.slave s_axi
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [60:0] DEPTH_IDX = 61'(DEPTH_WORDS);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_WAIT  = 3'd1;
  localparam logic [2:0] RD_BURST = 3'd2;
  localparam logic [2:0] WR_DATA  = 3'd3;
  localparam logic [2:0] WR_RESP  = 3'd4;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [2:0]  state_reg, state_next;
  logic [60:0] idx_reg, idx_next;
  logic [7:0]  len_reg, len_next;
  logic [7:0]  beat_reg, beat_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        size_err_reg, size_err_next;
  logic        wr_err_reg, wr_err_next;
  logic        rd_zero_reg, rd_zero_next;
  logic [1:0]  rresp_reg, rresp_next;
  logic [1:0]  bresp_reg, bresp_next;

  logic [63:0] start_off;
  logic [63:0] lane_rdata;
  logic        last_beat, beat_err, rd_err, burst_err;
  logic        rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic        unused_bits;

  // Write address wins when both requests arrive together, so offset the AW address first.
  assign start_off = (s_axi.awvalid ? s_axi.awaddr : s_axi.araddr) - BASE_ADDR;
  assign last_beat = (beat_reg == len_reg);
  assign beat_err  = size_err_reg || (idx_reg >= DEPTH_IDX);
  assign rd_err    = size_err_reg || (idx_next >= DEPTH_IDX);
  assign rd_addr   = idx_next[AW-1:0];
  assign wr_addr   = idx_reg[AW-1:0];
  assign unused_bits = ^{s_axi.arburst, s_axi.awburst, start_off[2:0]};

  assign s_axi.awready = !reset && (state_reg == IDLE);
  assign s_axi.arready = !reset && (state_reg == IDLE) && !s_axi.awvalid;
  assign s_axi.rvalid  = (state_reg == RD_BURST);
  assign s_axi.rlast   = (state_reg == RD_BURST) && last_beat;
  assign s_axi.rdata   = rd_zero_reg ? 64'h0 : lane_rdata;
  assign s_axi.rresp   = rresp_reg;
  assign s_axi.wready  = (state_reg == WR_DATA);
  assign s_axi.bvalid  = (state_reg == WR_RESP);
  assign s_axi.bresp   = bresp_reg;

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    len_next      = len_reg;
    beat_next     = beat_reg;
    cnt_next      = cnt_reg;
    size_err_next = size_err_reg;
    wr_err_next   = wr_err_reg;
    bresp_next    = bresp_reg;
    burst_err     = wr_err_reg;
    rd_en         = 1'b0;
    wr_en         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s_axi.awvalid) begin
          idx_next      = start_off[63:3];
          len_next      = s_axi.awlen;
          beat_next     = 8'd0;
          size_err_next = (s_axi.awsize != 3'b011);
          wr_err_next   = 1'b0;
          state_next    = WR_DATA;
        end else if (s_axi.arvalid) begin
          idx_next      = start_off[63:3];
          len_next      = s_axi.arlen;
          beat_next     = 8'd0;
          size_err_next = (s_axi.arsize != 3'b011);
          cnt_next      = 16'(READ_LATENCY - 1);
          state_next    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_reg == 16'd0) begin
          rd_en      = 1'b1;
          state_next = RD_BURST;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      RD_BURST: begin
        if (s_axi.rready) begin
          if (last_beat) begin
            state_next = IDLE;
          end else begin
            idx_next  = idx_reg + 61'd1;
            beat_next = beat_reg + 8'd1;
            rd_en     = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (s_axi.wvalid) begin
          wr_en       = !beat_err && !reset;
          burst_err   = wr_err_reg || beat_err || (s_axi.wlast != last_beat);
          wr_err_next = burst_err;
          if (last_beat) begin
            bresp_next = burst_err ? SLVERR : OKAY;
            state_next = WR_RESP;
          end else begin
            idx_next  = idx_reg + 61'd1;
            beat_next = beat_reg + 8'd1;
          end
        end
      end
      WR_RESP: begin
        if (s_axi.bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Error beats read back as zero; the flag travels with the registered fetch.
  always_comb begin
    rd_zero_next = rd_zero_reg;
    rresp_next   = rresp_reg;
    if (rd_en) begin
      rd_zero_next = rd_err;
      rresp_next   = rd_err ? SLVERR : OKAY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      len_reg      <= '0;
      beat_reg     <= '0;
      cnt_reg      <= '0;
      size_err_reg <= 1'b0;
      wr_err_reg   <= 1'b0;
      rd_zero_reg  <= 1'b1;
      rresp_reg    <= OKAY;
      bresp_reg    <= OKAY;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      len_reg      <= len_next;
      beat_reg     <= beat_next;
      cnt_reg      <= cnt_next;
      size_err_reg <= size_err_next;
      wr_err_reg   <= wr_err_next;
      rd_zero_reg  <= rd_zero_next;
      rresp_reg    <= rresp_next;
      bresp_reg    <= bresp_next;
    end
  end

  // One byte-wide RAM per strobe lane keeps byte writes to a single writer per array.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] q_reg;
      always_ff @(posedge clk) begin
        if (wr_en && s_axi.wstrb[gi]) mem[wr_addr] <= s_axi.wdata[gi*8 +: 8];
        if (rd_en) q_reg <= mem[rd_addr];
      end
      assign lane_rdata[gi*8 +: 8] = q_reg;
    end
  endgenerate
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: burst writes/reads, strobes, stalls,
// AR/AW collision, out-of-range beats and reset mid-burst.
module tb_axi_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_mem_responder_if s_axi();

  axi_mem_responder #(
    .DEPTH_WORDS (1024),
    .READ_LATENCY(4),
    .BASE_ADDR   (64'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .s_axi(s_axi)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] wbuf  [16];
  logic [63:0] rbuf  [16];
  logic [1:0]  rrbuf [16];
  logic        rlbuf [16];
  int          rd_beats;
  int          rd_lat;
  logic [1:0]  wr_resp;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // All phase tasks are entered and left 1 time unit after a rising edge.
  task automatic aw_phase(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size);
    int n;
    s_axi.awvalid = 1'b1; s_axi.awaddr = addr; s_axi.awlen = len;
    s_axi.awsize = size; s_axi.awburst = 2'b01;
    n = 0;
    @(negedge clk);
    while (!s_axi.awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check_val("aw_timeout", 64'(s_axi.awready), 64'd1);
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0;
  endtask

  task automatic w_phase(input int len, input logic [7:0] strb);
    int n;
    for (int b = 0; b <= len; b++) begin
      s_axi.wvalid = 1'b1; s_axi.wdata = wbuf[b]; s_axi.wstrb = strb;
      s_axi.wlast = (b == len);
      n = 0;
      @(negedge clk);
      while (!s_axi.wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check_val("w_timeout", 64'(s_axi.wready), 64'd1);
      @(posedge clk); #1;
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
  endtask

  task automatic b_phase(output logic [1:0] resp);
    int n;
    s_axi.bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi.bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check_val("b_timeout", 64'(s_axi.bvalid), 64'd1);
    resp = s_axi.bresp;
    @(posedge clk); #1;
    s_axi.bready = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input int len, input logic [2:0] size,
                          input logic [7:0] strb);
    aw_phase(addr, 8'(len), size);
    w_phase(len, strb);
    b_phase(wr_resp);
    $display("wr addr=%h len=%0d size=%0d strb=%h bresp=%0d", addr, len, size, strb, wr_resp);
  endtask

  task automatic ar_phase(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size);
    int n;
    s_axi.arvalid = 1'b1; s_axi.araddr = addr; s_axi.arlen = len;
    s_axi.arsize = size; s_axi.arburst = 2'b01;
    n = 0;
    @(negedge clk);
    while (!s_axi.arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check_val("ar_timeout", 64'(s_axi.arready), 64'd1);
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
    rd_lat = 0;
    do begin
      @(posedge clk); rd_lat++;
      @(negedge clk);
    end while (!s_axi.rvalid && rd_lat < 50);
    @(posedge clk); #1;
    $display("rd addr=%h len=%0d latency=%0d", addr, len, rd_lat);
  endtask

  task automatic r_phase(input int len, input bit toggle, input int stop_after);
    int k, guard;
    bit stall;
    logic [63:0] hold_d;
    logic hold_l;
    rd_beats = 0; k = 0; guard = 0; stall = 0; hold_d = '0; hold_l = 1'b0;
    while (rd_beats <= len && rd_beats != stop_after && guard < 200) begin
      guard++;
      s_axi.rready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      k++;
      @(negedge clk);
      if (s_axi.rvalid) begin
        if (stall) begin
          check_val("r_hold_data", s_axi.rdata, hold_d);
          check_val("r_hold_last", 64'(s_axi.rlast), 64'(hold_l));
        end
        if (s_axi.rready) begin
          rbuf[rd_beats] = s_axi.rdata; rrbuf[rd_beats] = s_axi.rresp;
          rlbuf[rd_beats] = s_axi.rlast; rd_beats++; stall = 0;
        end else begin
          stall = 1; hold_d = s_axi.rdata; hold_l = s_axi.rlast;
        end
      end
      @(posedge clk); #1;
    end
    s_axi.rready = 1'b0;
    if (guard >= 200) check_val("r_timeout", 64'(rd_beats), 64'(len + 1));
  endtask

  initial begin
    s_axi.arvalid = 0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arsize = 3'b011; s_axi.arburst = 2'b01;
    s_axi.rready = 0;
    s_axi.awvalid = 0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = 3'b011; s_axi.awburst = 2'b01;
    s_axi.wvalid = 0; s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 0; s_axi.bready = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_arready", 64'(s_axi.arready), 64'd0);
    check_val("rst_awready", 64'(s_axi.awready), 64'd0);
    check_val("rst_rvalid",  64'(s_axi.rvalid),  64'd0);
    check_val("rst_wready",  64'(s_axi.wready),  64'd0);
    check_val("rst_bvalid",  64'(s_axi.bvalid),  64'd0);
    check_val("rst_rdata",   s_axi.rdata,        64'd0);
    check_val("rst_rresp",   64'(s_axi.rresp),   64'd0);
    check_val("rst_rlast",   64'(s_axi.rlast),   64'd0);
    check_val("rst_bresp",   64'(s_axi.bresp),   64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("idle_arready", 64'(s_axi.arready), 64'd1);
    check_val("idle_awready", 64'(s_axi.awready), 64'd1);
    @(posedge clk); #1;

    // 1: burst write then burst read, fixed latency
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
    do_write(64'h40, 3, 3'b011, 8'hFF);
    check_val("t1_bresp", 64'(wr_resp), 64'd0);
    ar_phase(64'h40, 8'd3, 3'b011);
    check_val("t1_latency", 64'(rd_lat), 64'd4);
    r_phase(3, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t1_rdata%0d", i), rbuf[i], 64'(i + 1));
      check_val($sformatf("t1_rlast%0d", i), 64'(rlbuf[i]), 64'(i == 3));
      check_val($sformatf("t1_rresp%0d", i), 64'(rrbuf[i]), 64'd0);
    end

    // 2: partial strobe merges with existing word
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(64'h40, 0, 3'b011, 8'hFF);
    wbuf[0] = 64'h0000_0000_AABB_CCDD;
    do_write(64'h40, 0, 3'b011, 8'h0F);
    check_val("t2_bresp", 64'(wr_resp), 64'd0);
    ar_phase(64'h40, 8'd0, 3'b011);
    r_phase(0, 1'b0, -1);
    check_val("t2_rdata", rbuf[0], 64'hFFFF_FFFF_AABB_CCDD);
    check_val("t2_rlast", 64'(rlbuf[0]), 64'd1);

    // 3: eight-beat read with rready stalls
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    do_write(64'h40, 7, 3'b011, 8'hFF);
    ar_phase(64'h40, 8'd7, 3'b011);
    r_phase(7, 1'b1, -1);
    check_val("t3_beats", 64'(rd_beats), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("t3_rdata%0d", i), rbuf[i], 64'hA5A5_0000_0000_0000 | 64'(i));
      check_val($sformatf("t3_rlast%0d", i), 64'(rlbuf[i]), 64'(i == 7));
    end
    @(negedge clk);
    check_val("t3_rvalid_after", 64'(s_axi.rvalid), 64'd0);
    @(posedge clk); #1;

    // 4: simultaneous AR and AW, write goes first
    s_axi.arvalid = 1'b1; s_axi.araddr = 64'h200; s_axi.arlen = 8'd0; s_axi.arsize = 3'b011;
    s_axi.awvalid = 1'b1; s_axi.awaddr = 64'h200; s_axi.awlen = 8'd0; s_axi.awsize = 3'b011;
    @(negedge clk);
    check_val("t4_awready", 64'(s_axi.awready), 64'd1);
    check_val("t4_arready", 64'(s_axi.arready), 64'd0);
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0;
    @(negedge clk);
    check_val("t4_arready_wr", 64'(s_axi.arready), 64'd0);
    @(posedge clk); #1;
    wbuf[0] = 64'hDEAD_BEEF_0000_1234;
    w_phase(0, 8'hFF);
    b_phase(wr_resp);
    $display("wr addr=%h len=0 size=3 strb=ff bresp=%0d", 64'h200, wr_resp);
    check_val("t4_bresp", 64'(wr_resp), 64'd0);
    ar_phase(64'h200, 8'd0, 3'b011);
    r_phase(0, 1'b0, -1);
    check_val("t4_rdata", rbuf[0], 64'hDEAD_BEEF_0000_1234);

    // 5: read running off the end of storage
    wbuf[0] = 64'h0123_4567_89AB_CDEF;
    do_write(64'h1FF8, 0, 3'b011, 8'hFF);
    ar_phase(64'h1FF8, 8'd1, 3'b011);
    r_phase(1, 1'b0, -1);
    check_val("t5_rdata0", rbuf[0], 64'h0123_4567_89AB_CDEF);
    check_val("t5_rresp0", 64'(rrbuf[0]), 64'd0);
    check_val("t5_rdata1", rbuf[1], 64'd0);
    check_val("t5_rresp1", 64'(rrbuf[1]), 64'd2);
    check_val("t5_rlast1", 64'(rlbuf[1]), 64'd1);
    wbuf[0] = 64'h1; wbuf[1] = 64'h2;
    do_write(64'h1FF8, 1, 3'b011, 8'hFF);
    check_val("t5_wr_oor_bresp", 64'(wr_resp), 64'd2);
    wbuf[0] = 64'h5555_5555_5555_5555;
    do_write(64'h40, 0, 3'b010, 8'hFF);
    check_val("t5_size_bresp", 64'(wr_resp), 64'd2);
    ar_phase(64'h47, 8'd0, 3'b011);
    r_phase(0, 1'b0, -1);
    check_val("t5_unaligned_rdata", rbuf[0], 64'hA5A5_0000_0000_0000);

    // 6: reset after two of four beats
    ar_phase(64'h40, 8'd3, 3'b011);
    r_phase(3, 1'b0, 2);
    check_val("t6_beats", 64'(rd_beats), 64'd2);
    check_val("t6_rdata1", rbuf[1], 64'hA5A5_0000_0000_0001);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("t6_rvalid", 64'(s_axi.rvalid), 64'd0);
    check_val("t6_rlast",  64'(s_axi.rlast),  64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("t6_idle_arready", 64'(s_axi.arready), 64'd1);
    @(posedge clk); #1;
    ar_phase(64'h48, 8'd0, 3'b011);
    r_phase(0, 1'b0, -1);
    check_val("t6_fresh_rdata", rbuf[0], 64'hA5A5_0000_0000_0001);
    check_val("t6_fresh_rlast", 64'(rlbuf[0]), 64'd1);
    check_val("t6_fresh_rresp", 64'(rrbuf[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
